// File: rtl/multi_pulse_counter.sv
// Multi-channel pulse counter: synchronised, glitch-filtered inputs feed per-channel event counters
// with wrap/saturate, sticky overflow, and an atomic snapshot bank with optional clear-on-snapshot.
module multi_pulse_counter #(
    parameter int NUM_CH      = 4,
    parameter int CNT_WIDTH   = 8,
    parameter int FLT_LEN     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_CH-1:0]             i_cnt_en,
    input  logic [NUM_CH-1:0]             i_cnt_in,
    input  logic [NUM_CH-1:0]             i_cnt_rst,
    input  logic                          i_sat_mode,
    input  logic                          i_snap,
    input  logic                          i_snap_clr,
    output logic [NUM_CH*CNT_WIDTH-1:0]   o_cnt,
    output logic [NUM_CH-1:0]             o_level,
    output logic [NUM_CH-1:0]             o_ovf,
    output logic [NUM_CH*CNT_WIDTH-1:0]   o_snap,
    output logic [NUM_CH-1:0]             o_snap_ovf,
    output logic                          o_snap_vld
);

    localparam int RW = $clog2(FLT_LEN + 1);
    localparam logic [RW-1:0]        R_LAST  = RW'(FLT_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic snap_clr;
    assign snap_clr = i_snap & i_snap_clr;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [RW-1:0]          run_q;
        logic                   level_q;
        logic [CNT_WIDTH-1:0]   cnt_q;
        logic                   ovf_q;
        logic [CNT_WIDTH-1:0]   snap_q;
        logic                   snap_ovf_q;
        logic                   s;
        logic                   ev;

        assign s  = sync_q[SYNC_STAGES-1];
        // Accepted 0->1 transition; the counter consumes it in the same edge the level flips.
        assign ev = i_cnt_en[n] && s && !level_q && (run_q == R_LAST);

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], i_cnt_in[n]};
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                run_q   <= '0;
                level_q <= 1'b0;
            end else if (!i_cnt_en[n] || (s == level_q)) begin
                run_q <= '0;
            end else if (run_q == R_LAST) begin
                level_q <= s;
                run_q   <= '0;
            end else begin
                run_q <= run_q + 1'b1;
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst || i_cnt_rst[n]) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (snap_clr) begin
                cnt_q <= {{(CNT_WIDTH-1){1'b0}}, ev};
                ovf_q <= 1'b0;
            end else if (ev) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_q <= cnt_q + 1'b1;
                end else begin
                    ovf_q <= 1'b1;
                    if (!i_sat_mode) begin
                        cnt_q <= '0;
                    end
                end
            end
        end

        // Snapshot takes the pre-update values, so a clearing snapshot still reports the old count.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                snap_q     <= '0;
                snap_ovf_q <= 1'b0;
            end else if (i_snap) begin
                snap_q     <= cnt_q;
                snap_ovf_q <= ovf_q;
            end
        end

        assign o_cnt[n*CNT_WIDTH +: CNT_WIDTH]  = cnt_q;
        assign o_snap[n*CNT_WIDTH +: CNT_WIDTH] = snap_q;
        assign o_level[n]    = level_q;
        assign o_ovf[n]      = ovf_q;
        assign o_snap_ovf[n] = snap_ovf_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_snap_vld <= 1'b0;
        end else begin
            o_snap_vld <= i_snap;
        end
    end

endmodule

// File: tb/tb_multi_pulse_counter.sv
// Scenario bench for multi_pulse_counter: expected counts are queued when stimulus is driven
// and popped when the DUT result is sampled on the falling edge.
module tb_multi_pulse_counter;

    localparam int NUM_CH = 4;
    localparam int W      = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_CH-1:0]    cnt_en;
    logic [NUM_CH-1:0]    cnt_in;
    logic [NUM_CH-1:0]    cnt_rst;
    logic                 sat_mode;
    logic                 snap;
    logic                 snap_clr;
    logic [NUM_CH*W-1:0]  o_cnt;
    logic [NUM_CH-1:0]    o_level;
    logic [NUM_CH-1:0]    o_ovf;
    logic [NUM_CH*W-1:0]  o_snap;
    logic [NUM_CH-1:0]    o_snap_ovf;
    logic                 o_snap_vld;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    multi_pulse_counter #(
        .NUM_CH(NUM_CH), .CNT_WIDTH(W), .FLT_LEN(16), .SYNC_STAGES(2)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_cnt_en(cnt_en), .i_cnt_in(cnt_in),
        .i_cnt_rst(cnt_rst), .i_sat_mode(sat_mode), .i_snap(snap),
        .i_snap_clr(snap_clr), .o_cnt(o_cnt), .o_level(o_level), .o_ovf(o_ovf),
        .o_snap(o_snap), .o_snap_ovf(o_snap_ovf), .o_snap_vld(o_snap_vld)
    );

    function automatic logic [W-1:0] cnt_of(input int ch);
        return o_cnt[ch*W +: W];
    endfunction

    function automatic logic [W-1:0] snap_of(input int ch);
        return o_snap[ch*W +: W];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_pulse(input logic [NUM_CH-1:0] mask, input int hi, input int lo);
        cnt_in = mask;
        tick(hi);
        cnt_in = '0;
        tick(lo);
    endtask

    task automatic clear_all();
        cnt_rst = '1;
        tick(1);
        cnt_rst = '0;
    endtask

    task automatic test_reset();
        logic [W-1:0] e;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        exp_q.push_back(8'd1);
        drive_pulse(4'b0001, 20, 20);
        snap = 1'b1;
        tick(1);
        snap = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (cnt_of(0) !== e) begin n_fail++; $display("FAIL rst_precond_cnt0: got %0d want %0d", cnt_of(0), e); end
        // One reset cycle with every other input toggling.
        rst      = 1'b1;
        cnt_in   = NUM_CH'($urandom_range(0, 15));
        cnt_rst  = NUM_CH'($urandom_range(0, 15));
        snap     = 1'b1;
        snap_clr = 1'($urandom_range(0, 1));
        sat_mode = 1'($urandom_range(0, 1));
        tick(1);
        rst = 1'b0; cnt_in = '0; cnt_rst = '0; snap = 1'b0; snap_clr = 1'b0; sat_mode = 1'b0;
        n_checks++;
        if (o_cnt !== '0) begin n_fail++; $display("FAIL rst_cnt: got %h want 0", o_cnt); end
        n_checks++;
        if (o_snap !== '0) begin n_fail++; $display("FAIL rst_snap: got %h want 0", o_snap); end
        n_checks++;
        if ({o_level, o_ovf, o_snap_ovf, o_snap_vld} !== '0) begin
            n_fail++;
            $display("FAIL rst_flags: got lvl=%b ovf=%b sovf=%b vld=%b want all 0",
                     o_level, o_ovf, o_snap_ovf, o_snap_vld);
        end
        // Long reset with all lines high: nothing may count.
        rst = 1'b1; cnt_in = '1;
        tick(20);
        rst = 1'b0; cnt_in = '0;
        tick(4);
        n_checks++;
        if ({o_cnt, o_level} !== '0) begin n_fail++; $display("FAIL rst_hold: got cnt=%h lvl=%b want 0", o_cnt, o_level); end
    endtask

    task automatic test_latency();
        logic [W-1:0] e;
        cnt_in[0] = 1'b1;
        exp_q.push_back(8'd0);
        exp_q.push_back(8'd1);
        tick(17);
        e = exp_q.pop_front();
        n_checks++;
        if (cnt_of(0) !== e || o_level[0] !== 1'b0) begin
            n_fail++; $display("FAIL latency_edge16: got cnt=%0d lvl=%b want cnt=%0d lvl=0", cnt_of(0), o_level[0], e);
        end
        tick(1);
        e = exp_q.pop_front();
        n_checks++;
        if (cnt_of(0) !== e || o_level[0] !== 1'b1) begin
            n_fail++; $display("FAIL latency_edge17: got cnt=%0d lvl=%b want cnt=%0d lvl=1", cnt_of(0), o_level[0], e);
        end
        tick(22);
        cnt_in[0] = 1'b0;
        tick(20);
        clear_all();
        exp_q.push_back(8'd0);
        drive_pulse(4'b0001, 15, 20);
        e = exp_q.pop_front();
        n_checks++;
        if (cnt_of(0) !== e) begin n_fail++; $display("FAIL short_pulse15: got %0d want %0d", cnt_of(0), e); end
        exp_q.push_back(8'd1);
        drive_pulse(4'b0001, 16, 20);
        e = exp_q.pop_front();
        n_checks++;
        if (cnt_of(0) !== e) begin n_fail++; $display("FAIL exact_pulse16: got %0d want %0d", cnt_of(0), e); end
    endtask

    task automatic test_glitch();
        logic [W-1:0] e;
        clear_all();
        exp_q.push_back(8'd1);
        cnt_in[1] = 1'b1; tick(30);
        cnt_in[1] = 1'b0; tick(10);
        cnt_in[1] = 1'b1; tick(30);
        e = exp_q.pop_front();
        n_checks++;
        if (cnt_of(1) !== e) begin n_fail++; $display("FAIL glitch_rearm: got %0d want %0d", cnt_of(1), e); end
        exp_q.push_back(8'd2);
        cnt_in[1] = 1'b0; tick(20);
        cnt_in[1] = 1'b1; tick(20);
        cnt_in[1] = 1'b0; tick(20);
        e = exp_q.pop_front();
        n_checks++;
        if (cnt_of(1) !== e) begin n_fail++; $display("FAIL glitch_second: got %0d want %0d", cnt_of(1), e); end
        n_checks++;
        if (cnt_of(0) !== 8'd0 || cnt_of(2) !== 8'd0 || cnt_of(3) !== 8'd0) begin
            n_fail++; $display("FAIL glitch_other_ch: got %h want ch0/2/3 zero", o_cnt);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] e;
        clear_all();
        sat_mode = 1'b1;
        exp_q.push_back(8'd255);
        repeat (255) drive_pulse(4'b1000, 16, 16);
        e = exp_q.pop_front();
        n_checks++;
        if (cnt_of(3) !== e || o_ovf[3] !== 1'b0) begin
            n_fail++; $display("FAIL ovf_at_max: got cnt=%0d ovf=%b want cnt=%0d ovf=0", cnt_of(3), o_ovf[3], e);
        end
        exp_q.push_back(8'd255);
        drive_pulse(4'b1000, 16, 16);
        e = exp_q.pop_front();
        n_checks++;
        if (cnt_of(3) !== e || o_ovf[3] !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sat: got cnt=%0d ovf=%b want cnt=%0d ovf=1", cnt_of(3), o_ovf[3], e);
        end
        sat_mode = 1'b0;
        exp_q.push_back(8'd255);
        tick(3);
        e = exp_q.pop_front();
        n_checks++;
        if (cnt_of(3) !== e || o_ovf[3] !== 1'b1) begin
            n_fail++; $display("FAIL sat_mode_change: got cnt=%0d ovf=%b want cnt=%0d ovf=1", cnt_of(3), o_ovf[3], e);
        end
        cnt_rst[3] = 1'b1; tick(1); cnt_rst[3] = 1'b0;
        n_checks++;
        if (cnt_of(3) !== 8'd0 || o_ovf[3] !== 1'b0) begin
            n_fail++; $display("FAIL cnt_rst_clears: got cnt=%0d ovf=%b want 0/0", cnt_of(3), o_ovf[3]);
        end
        exp_q.push_back(8'd0);
        repeat (256) drive_pulse(4'b1000, 16, 16);
        e = exp_q.pop_front();
        n_checks++;
        if (cnt_of(3) !== e || o_ovf[3] !== 1'b1) begin
            n_fail++; $display("FAIL ovf_wrap: got cnt=%0d ovf=%b want cnt=%0d ovf=1", cnt_of(3), o_ovf[3], e);
        end
        exp_q.push_back(8'd1);
        drive_pulse(4'b1000, 16, 16);
        e = exp_q.pop_front();
        n_checks++;
        if (cnt_of(3) !== e || o_ovf[3] !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky: got cnt=%0d ovf=%b want cnt=%0d ovf=1", cnt_of(3), o_ovf[3], e);
        end
    endtask

    task automatic test_snapshot();
        logic [W-1:0] e;
        clear_all();
        sat_mode = 1'b0;
        exp_q.push_back(8'd7);
        repeat (263) drive_pulse(4'b0110, 16, 16);
        e = exp_q.pop_front();
        n_checks++;
        if (cnt_of(1) !== e || o_ovf[1] !== 1'b1) begin
            n_fail++; $display("FAIL snap_precond: got cnt=%0d ovf=%b want cnt=%0d ovf=1", cnt_of(1), o_ovf[1], e);
        end
        // Events on ch1/ch2 land on edge 17, together with a clearing snapshot and ch2 clear.
        exp_q.push_back(8'd7);
        exp_q.push_back(8'd1);
        cnt_in = 4'b0110;
        tick(17);
        snap = 1'b1; snap_clr = 1'b1; cnt_rst = 4'b0100;
        tick(1);
        snap = 1'b0; snap_clr = 1'b0; cnt_rst = '0;
        e = exp_q.pop_front();
        n_checks++;
        if (snap_of(1) !== e || o_snap_ovf[1] !== 1'b1 || o_snap_vld !== 1'b1) begin
            n_fail++; $display("FAIL snap_capture_ch1: got snap=%0d sovf=%b vld=%b want snap=%0d sovf=1 vld=1",
                               snap_of(1), o_snap_ovf[1], o_snap_vld, e);
        end
        n_checks++;
        if (snap_of(2) !== 8'd7 || o_snap_ovf[2] !== 1'b1 || snap_of(0) !== 8'd0) begin
            n_fail++; $display("FAIL snap_capture_other: got ch2=%0d sovf2=%b ch0=%0d want 7/1/0",
                               snap_of(2), o_snap_ovf[2], snap_of(0));
        end
        e = exp_q.pop_front();
        n_checks++;
        if (cnt_of(1) !== e || o_ovf[1] !== 1'b0) begin
            n_fail++; $display("FAIL snap_clr_event_kept: got cnt=%0d ovf=%b want cnt=%0d ovf=0", cnt_of(1), o_ovf[1], e);
        end
        n_checks++;
        if (cnt_of(2) !== 8'd0 || o_ovf[2] !== 1'b0) begin
            n_fail++; $display("FAIL cnt_rst_drops_event: got cnt=%0d ovf=%b want 0/0", cnt_of(2), o_ovf[2]);
        end
        tick(1);
        n_checks++;
        if (o_snap_vld !== 1'b0 || snap_of(1) !== 8'd7) begin
            n_fail++; $display("FAIL snap_vld_one_cycle: got vld=%b snap=%0d want vld=0 snap=7", o_snap_vld, snap_of(1));
        end
        cnt_in = '0;
        tick(20);
    endtask

    task automatic test_back_to_back();
        snap_clr = 1'b1;
        tick(1);
        snap_clr = 1'b0;
        n_checks++;
        if (cnt_of(1) !== 8'd1 || o_snap_vld !== 1'b0) begin
            n_fail++; $display("FAIL clr_without_snap: got cnt=%0d vld=%b want cnt=1 vld=0", cnt_of(1), o_snap_vld);
        end
        snap = 1'b1; snap_clr = 1'b1;
        tick(1);
        snap_clr = 1'b0;
        n_checks++;
        if (snap_of(1) !== 8'd1 || cnt_of(1) !== 8'd0 || o_snap_vld !== 1'b1) begin
            n_fail++; $display("FAIL b2b_first: got snap=%0d cnt=%0d vld=%b want 1/0/1", snap_of(1), cnt_of(1), o_snap_vld);
        end
        tick(1);
        snap = 1'b0;
        n_checks++;
        if (snap_of(1) !== 8'd0 || o_snap_vld !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second: got snap=%0d vld=%b want 0/1", snap_of(1), o_snap_vld);
        end
        tick(1);
        n_checks++;
        if (o_snap_vld !== 1'b0) begin n_fail++; $display("FAIL b2b_vld_end: got %b want 0", o_snap_vld); end
    endtask

    task automatic test_disturb();
        logic [W-1:0] e;
        cnt_in[0] = 1'b1;
        tick(12);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_q.push_back(8'd0);
        exp_q.push_back(8'd1);
        tick(17);
        e = exp_q.pop_front();
        n_checks++;
        if (cnt_of(0) !== e) begin n_fail++; $display("FAIL mid_rst_early: got %0d want %0d", cnt_of(0), e); end
        tick(1);
        e = exp_q.pop_front();
        n_checks++;
        if (cnt_of(0) !== e) begin n_fail++; $display("FAIL mid_rst_full: got %0d want %0d", cnt_of(0), e); end
        cnt_in[0] = 1'b0;
        tick(20);
        cnt_in[0] = 1'b1;
        tick(12);
        cnt_en[0] = 1'b0;
        tick(1);
        cnt_en[0] = 1'b1;
        exp_q.push_back(8'd1);
        exp_q.push_back(8'd2);
        tick(15);
        e = exp_q.pop_front();
        n_checks++;
        if (cnt_of(0) !== e || o_level[0] !== 1'b0) begin
            n_fail++; $display("FAIL en_drop_early: got cnt=%0d lvl=%b want cnt=%0d lvl=0", cnt_of(0), o_level[0], e);
        end
        tick(1);
        e = exp_q.pop_front();
        n_checks++;
        if (cnt_of(0) !== e) begin n_fail++; $display("FAIL en_drop_full: got %0d want %0d", cnt_of(0), e); end
        cnt_in[0] = 1'b0;
        tick(20);
    endtask

    initial begin
        rst = 1'b1; cnt_en = '1; cnt_in = '0; cnt_rst = '0;
        sat_mode = 1'b0; snap = 1'b0; snap_clr = 1'b0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_glitch();
        test_overflow();
        test_snapshot();
        test_back_to_back();
        test_disturb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
